// File: rtl/imem_loader.sv
// Byte-stream boot loader: parses a big-endian {count, words, xor checksum} image from the UART
// and writes it into the instruction RAM, holding the CPU in reset until the image verifies.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  MemWrite,
    output logic [30:0]           WriteAddress,
    output logic [31:0]           WriteData,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        StCntHi,
        StCntLo,
        StData,
        StCheck,
        StDone,
        StError
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            cnt_hi_q, cnt_hi_d;
    logic [15:0]           count_q, count_d;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  mem_write_q, mem_write_d;
    logic [30:0]           waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  hold_q, hold_d;
    logic [15:0]           n_word;

    assign n_word = {cnt_hi_q, rx_data};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StCntHi;
            cnt_hi_q    <= 8'h00;
            count_q     <= 16'h0000;
            byte_cnt_q  <= 2'd0;
            asm_q       <= 24'h000000;
            csum_q      <= 8'h00;
            mem_write_q <= 1'b0;
            waddr_q     <= 31'h0;
            wdata_q     <= 32'h0;
            words_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            hold_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_hi_q    <= cnt_hi_d;
            count_q     <= count_d;
            byte_cnt_q  <= byte_cnt_d;
            asm_q       <= asm_d;
            csum_q      <= csum_d;
            mem_write_q <= mem_write_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            words_q     <= words_d;
            done_q      <= done_d;
            error_q     <= error_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_hi_d    = cnt_hi_q;
        count_d     = count_q;
        byte_cnt_d  = byte_cnt_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        mem_write_d = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        words_d     = words_q;

        if (rx_valid) begin
            unique case (state_q)
                StCntHi: begin
                    cnt_hi_d = rx_data;
                    state_d  = StCntLo;
                end
                StCntLo: begin
                    count_d    = n_word;
                    byte_cnt_d = 2'd0;
                    if (32'(n_word) > Depth) begin
                        state_d = StError;
                    end else if (n_word == 16'h0000) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StData;
                    end
                end
                StData: begin
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    asm_d      = {asm_q[15:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        // Count never exceeds Depth, so the index is always in range here.
                        mem_write_d = 1'b1;
                        wdata_d     = {asm_q, rx_data};
                        waddr_d     = 31'({words_q[ADDR_WIDTH-1:0], 2'b00});
                        words_d     = words_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
                        if (32'(words_d) == 32'(count_q)) begin
                            state_d = StCheck;
                        end
                    end
                end
                StCheck: begin
                    if (rx_data == csum_q) begin
                        state_d = StDone;
                    end else begin
                        state_d = StError;
                    end
                end
                default: begin
                end
            endcase
        end

        done_d  = (state_d == StDone);
        error_d = (state_d == StError);
        hold_d  = (state_d != StDone);
    end

    assign MemWrite     = mem_write_q;
    assign WriteAddress = waddr_q;
    assign WriteData    = wdata_q;
    assign cpu_hold     = hold_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader: byte streams with hand-computed write sequences.
module tb_imem_loader;

    localparam int unsigned AW = 8;

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          MemWrite;
    logic [30:0]   WriteAddress;
    logic [31:0]   WriteData;
    logic          cpu_hold;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int tests;
    int fails;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .MemWrite     (MemWrite),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_error   (load_error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  b;
        logic        mw;
        logic [30:0] addr;
        logic [31:0] data;
    } vec_t;

    vec_t img [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Byte is presented for exactly one edge; outputs are sampled 1 time unit after that edge.
    task automatic send(input logic [7:0] b, input int gap, input logic exp_mw,
                        input logic [30:0] ea, input logic [31:0] ed);
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
            check("idle_memwrite", {31'h0, MemWrite}, 32'h0);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h5A;
        check("memwrite", {31'h0, MemWrite}, {31'h0, exp_mw});
        if (exp_mw) begin
            check("write_addr", {1'b0, WriteAddress}, {1'b0, ea});
            check("write_data", WriteData, ed);
        end
    endtask

    task automatic run_img(input int max_gap);
        for (int i = 0; i < 15; i++) begin
            send(img[i].b, (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0,
                 img[i].mw, img[i].addr, img[i].data);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h,
                                input logic [AW:0] w);
        check({tag, "_done"},  {31'h0, load_done},  {31'h0, d});
        check({tag, "_error"}, {31'h0, load_error}, {31'h0, e});
        check({tag, "_hold"},  {31'h0, cpu_hold},   {31'h0, h});
        check({tag, "_words"}, 32'(words_loaded),    32'(w));
        check({tag, "_excl"},  {31'h0, load_done & load_error}, 32'h0);
    endtask

    task automatic send_ignored(input int n);
        for (int i = 0; i < n; i++) begin
            send(8'(8'h30 + i), 0, 1'b0, 31'h0, 32'h0);
        end
    endtask

    initial begin
        logic [7:0]  cs;
        logic [31:0] w;
        tests = 0;
        fails = 0;

        img[0]  = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[1]  = '{8'h03, 1'b0, 31'h0, 32'h0};
        img[2]  = '{8'h08, 1'b0, 31'h0, 32'h0};
        img[3]  = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[4]  = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[5]  = '{8'h03, 1'b1, 31'h0, 32'h08000003};
        img[6]  = '{8'h0c, 1'b0, 31'h0, 32'h0};
        img[7]  = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[8]  = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[9]  = '{8'h15, 1'b1, 31'h4, 32'h0c000015};
        img[10] = '{8'h08, 1'b0, 31'h0, 32'h0};
        img[11] = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[12] = '{8'h00, 1'b0, 31'h0, 32'h0};
        img[13] = '{8'h16, 1'b1, 31'h8, 32'h08000016};
        // XOR of the twelve data bytes.
        img[14] = '{8'h0c, 1'b0, 31'h0, 32'h0};

        // Reset values.
        do_reset();
        check("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        check("rst_addr", {1'b0, WriteAddress}, 32'h0);
        check("rst_data", WriteData, 32'h0);
        check_status("rst", 1'b0, 1'b0, 1'b1, '0);

        // Three-word image, back-to-back bytes, good checksum.
        run_img(0);
        check_status("img_ok", 1'b1, 1'b0, 1'b0, 9'd3);
        send_ignored(3);
        check_status("img_ok_after", 1'b1, 1'b0, 1'b0, 9'd3);

        // Same image with a bad checksum.
        do_reset();
        img[14].b = 8'h11;
        run_img(0);
        check_status("bad_cs", 1'b0, 1'b1, 1'b1, 9'd3);
        send_ignored(6);
        check_status("bad_cs_after", 1'b0, 1'b1, 1'b1, 9'd3);
        img[14].b = 8'h0c;

        // Count 257 overflows a 256-word RAM.
        do_reset();
        send(8'h01, 0, 1'b0, 31'h0, 32'h0);
        check("ovf_err_early", {31'h0, load_error}, 32'h0);
        send(8'h01, 0, 1'b0, 31'h0, 32'h0);
        check_status("ovf", 1'b0, 1'b1, 1'b1, '0);
        send_ignored(8);
        check_status("ovf_after", 1'b0, 1'b1, 1'b1, '0);

        // Empty images.
        do_reset();
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        check_status("empty_ok", 1'b1, 1'b0, 1'b0, '0);
        do_reset();
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h01, 0, 1'b0, 31'h0, 32'h0);
        check_status("empty_bad", 1'b0, 1'b1, 1'b1, '0);

        // Same image with random idle gaps between bytes.
        do_reset();
        run_img(5);
        check_status("gaps", 1'b1, 1'b0, 1'b0, 9'd3);

        // Abort after two of four words, then load a one-word image.
        do_reset();
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h04, 0, 1'b0, 31'h0, 32'h0);
        for (int i = 2; i < 10; i++) begin
            send(img[i].b, 1, img[i].mw, img[i].addr, img[i].data);
        end
        check_status("abort_mid", 1'b0, 1'b0, 1'b1, 9'd2);
        do_reset();
        check_status("abort_rst", 1'b0, 1'b0, 1'b1, '0);
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h01, 0, 1'b0, 31'h0, 32'h0);
        send(8'h20, 0, 1'b0, 31'h0, 32'h0);
        send(8'h04, 0, 1'b0, 31'h0, 32'h0);
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        send(8'h03, 0, 1'b1, 31'h0, 32'h20040003);
        send(8'h27, 0, 1'b0, 31'h0, 32'h0);
        check_status("reload", 1'b1, 1'b0, 1'b0, 9'd1);

        // Full-capacity image: 256 words, last write at 0x3FC.
        do_reset();
        send(8'h01, 0, 1'b0, 31'h0, 32'h0);
        send(8'h00, 0, 1'b0, 31'h0, 32'h0);
        cs = 8'h00;
        for (int k = 0; k < 256; k++) begin
            w  = {8'hA0, 8'(k), 8'h5C, 8'(k) ^ 8'hFF};
            cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
            send(w[31:24], 0, 1'b0, 31'h0, 32'h0);
            send(w[23:16], 0, 1'b0, 31'h0, 32'h0);
            send(w[15:8],  0, 1'b0, 31'h0, 32'h0);
            send(w[7:0],   0, 1'b1, 31'(k * 4), w);
        end
        check_status("full_pre", 1'b0, 1'b0, 1'b1, 9'd256);
        send(cs, 0, 1'b0, 31'h0, 32'h0);
        check_status("full", 1'b1, 1'b0, 1'b0, 9'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
